piradip_cdc_reg_bank_tx: RTL and testbench
==========================================

Name: piradip_cdc_reg_bank_tx

Overview:
- Source-domain front end for a bank of CHANNELS configuration/status registers crossing to another clock through one shared handshake CDC primitive.
- Detects per-channel value changes, queues them as pending bits and arbitrates round-robin.
- Drives the primitive's send/receive handshake with {channel index, data} words.
- Coalesces repeated changes so the destination always ends up with the latest value of every channel.

Parameters:
- WIDTH, 32, data bits per channel.
- CHANNELS, 4, number of registers in the bank (1..64).
- IDX_W, $clog2(CHANNELS) with a minimum of 1, width of the channel index field (derived; do not override).

Ports:
- src_clk  in  1  source clock; all logic is in this domain.
- src_rst  in  1  synchronous active-high reset.
- src_data  in  CHANNELS*WIDTH  register bank; channel i occupies bits [i*WIDTH +: WIDTH].
- src_force  in  CHANNELS  one-cycle pulse per channel: mark the channel pending even if its value is unchanged.
- cdc_word  out  IDX_W+WIDTH  {index, data} to the CDC primitive's src_in.
- cdc_send  out  1  to the primitive's src_send.
- cdc_rcv  in  1  from the primitive's src_rcv.
- pending  out  CHANNELS  current pending mask.
- busy  out  1  high when not in IDLE or when pending != 0.

Behaviour:
- Reset values:
  - cdc_send=0, cdc_word=0, pending=0, busy=0.
  - Shadow copy of src_data = 0.
  - Arbiter pointer = channel 0; FSM = IDLE.
- Change detect: each cycle the shadow register is loaded with src_data. Channel i is set pending when its src_data slice differs from its shadow slice, or when src_force[i]=1.
- First cycle out of reset: the shadow is 0, so every channel with a nonzero value becomes pending. This is required; it gives the destination its initial sync.
- FSM states:
  - IDLE: if pending != 0 and cdc_rcv=0, grant one channel. Latch cdc_word = {index, current src_data slice}, clear that pending bit and go to SEND. cdc_send rises in the cycle after the grant.
  - SEND: cdc_send=1 and cdc_word held stable. When cdc_rcv=1, drop cdc_send and go to ACK_LOW.
  - ACK_LOW: cdc_send=0. When cdc_rcv=0, go to IDLE.
- Minimum spacing: grant-to-grant spacing is bounded below by the primitive's round trip. No new grant is ever issued while cdc_rcv=1.
- Arbitration: round-robin. Search starts at the channel after the last grant, wrapping from CHANNELS-1 to 0. A single pending channel is granted repeatedly without starvation of others.
- Coalescing: a change on a channel already pending leaves it pending (single bit). A change on the channel currently in flight re-sets its pending bit, so it is sent again with the newer value after the current transfer.
- Simultaneous events: if the grant clears bit i in the same cycle a change or force sets bit i, the set wins (bit i remains 1).
- Data captured: the value in cdc_word is src_data at the grant cycle, not the shadow value.
- Reset mid-transfer:
  - cdc_send drops in the next cycle and all pending bits clear; the FSM returns to IDLE.
  - While cdc_rcv=1 after reset, IDLE issues no grants.
  - Once cdc_rcv=0, channels whose value is nonzero are re-sent through the shadow-reset mechanism.
- CHANNELS=1: IDX_W=1, index field is always 0, and the arbiter degenerates to a single request.

Optional Feature:
- Macro: PIRADIP_CDC_COALESCE_COUNT_EN.
- When defined:
  - Adds output coalesced_cnt, 16 bits.
  - Increments by one for each cycle in which a channel that is already pending (and not being granted that cycle) sees a change or force. If several channels coalesce in one cycle, it increments by their count.
  - Saturates at 0xFFFF and resets to 0.
- When undefined: the port and counter logic are absent; behaviour is otherwise identical.

Decomposition:
- Package piradip_cdc_pkg:
  - typedef enum logic [1:0] {IDLE, SEND, ACK_LOW} cdc_tx_state_t.
  - Function idx_width(n) returning max(1, clog2(n)).
  - Localparam COALESCE_CNT_W = 16.
- Sub-module piradip_rr_arbiter #(N):
  - Inputs: req[N], advance.
  - Outputs: grant_valid, grant_idx.
  - Holds its own pointer; reused later by receive-side and multi-stream blocks.

Test Plan:
- Reset, then src_data ch0=0x0, ch1=0x5, others 0, with a CDC model that has 4-cycle ack latency. Required: exactly one transfer, cdc_word={1,0x00000005}, then busy returns to 0.
- Change ch2 to 0xA, 0xB, 0xC on three consecutive cycles while ch2 is in flight. Required: at most two transfers on ch2, and the last one carries 0xC.
- Pulse all four src_force bits in one cycle with the pointer at 0. Required: grant order 1,2,3,0 (pointer starts after last grant 0), each cdc_send preceded by cdc_rcv=0.
- Hold cdc_rcv=1 for 20 cycles while pending=0x3. Required: cdc_send stays 0 and no grant occurs until cdc_rcv falls.
- Assert src_rst during SEND. Required: next cycle cdc_send=0 and pending=0; after cdc_rcv falls, nonzero channels are re-sent.
- With PIRADIP_CDC_COALESCE_COUNT_EN defined, apply the scenario-2 stimulus. Required: coalesced_cnt=1 (only 0xC coalesces onto a pending ch2).

Source files
------------

// File: rtl/piradip_cdc_pkg.sv
// Shared types and helpers for the piradip register-bank CDC blocks.
package piradip_cdc_pkg;

    typedef enum logic [1:0] {IDLE, SEND, ACK_LOW} cdc_tx_state_t;

    localparam int COALESCE_CNT_W = 16;

    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piradip_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted index and wraps.
module piradip_rr_arbiter
    import piradip_cdc_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr;
    logic [IW:0]   cand;  // one extra bit so ptr + offset can pass N-1 before the wrap

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= N; i++) begin
            cand = {1'b0, ptr} + (IW+1)'(i);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!grant_valid && req[cand[IW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand[IW-1:0];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && grant_valid) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/piradip_cdc_reg_bank_tx.sv
// Source-side front end pushing changed register-bank channels through one handshake CDC.
// Optional coalesce counter output enabled by defining PIRADIP_CDC_COALESCE_COUNT_EN.
module piradip_cdc_reg_bank_tx
    import piradip_cdc_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    localparam int IDX_W   = idx_width(CHANNELS)
) (
    input  logic                      src_clk,
    input  logic                      src_rst,
    input  logic [CHANNELS*WIDTH-1:0] src_data,
    input  logic [CHANNELS-1:0]       src_force,
    output logic [IDX_W+WIDTH-1:0]    cdc_word,
    output logic                      cdc_send,
    input  logic                      cdc_rcv,
    output logic [CHANNELS-1:0]       pending,
    output logic                      busy
`ifdef PIRADIP_CDC_COALESCE_COUNT_EN
    ,
    output logic [COALESCE_CNT_W-1:0] coalesced_cnt
`endif
);

    typedef logic [CHANNELS-1:0][WIDTH-1:0] bank_t;

    bank_t               data_ch;
    bank_t               shadow;
    logic [CHANNELS-1:0] change;
    logic [CHANNELS-1:0] grant_mask;
    logic [CHANNELS-1:0] pending_nxt;
    cdc_tx_state_t       state, state_nxt;
    logic                grant;
    logic                arb_valid;
    logic [IDX_W-1:0]    arb_idx;

    assign data_ch = src_data;

    always_comb begin
        change = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            change[i] = (data_ch[i] != shadow[i]) || src_force[i];
        end
    end

    piradip_rr_arbiter #(.N(CHANNELS)) u_arb (
        .clk         (src_clk),
        .rst         (src_rst),
        .req         (pending),
        .advance     (grant),
        .grant_valid (arb_valid),
        .grant_idx   (arb_idx)
    );

    // A grant is never issued while the primitive still reports cdc_rcv.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                if (arb_valid && !cdc_rcv) begin
                    grant     = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (cdc_rcv) state_nxt = ACK_LOW;
            end
            ACK_LOW: begin
                if (!cdc_rcv) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant_mask = '0;
        if (grant) grant_mask[arb_idx] = 1'b1;
    end

    // Clear first, then set: a change in the grant cycle keeps the channel pending.
    assign pending_nxt = (pending & ~grant_mask) | change;

    // NOTE: the shadow bank is reset to zero on purpose; it triggers the post-reset resync.
    always_ff @(posedge src_clk) begin
        if (src_rst) begin
            state    <= IDLE;
            shadow   <= '0;
            pending  <= '0;
            cdc_send <= 1'b0;
            cdc_word <= '0;
        end else begin
            state    <= state_nxt;
            shadow   <= data_ch;
            pending  <= pending_nxt;
            cdc_send <= (state_nxt == SEND);
            if (grant) begin
                cdc_word <= {arb_idx, data_ch[arb_idx]};
            end
        end
    end

    assign busy = (state != IDLE) || (pending != '0);

`ifdef PIRADIP_CDC_COALESCE_COUNT_EN
    logic [COALESCE_CNT_W:0] cnt_sum;

    always_comb begin
        cnt_sum = {1'b0, coalesced_cnt};
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_sum = cnt_sum + (COALESCE_CNT_W+1)'(change[i] & pending[i] & ~grant_mask[i]);
        end
    end

    always_ff @(posedge src_clk) begin
        if (src_rst) begin
            coalesced_cnt <= '0;
        end else if (cnt_sum[COALESCE_CNT_W]) begin
            coalesced_cnt <= '1;
        end else begin
            coalesced_cnt <= cnt_sum[COALESCE_CNT_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_piradip_cdc_reg_bank_tx.sv
// Directed bench for piradip_cdc_reg_bank_tx with a 4-cycle-latency handshake model.
module tb_piradip_cdc_reg_bank_tx;

    localparam int W       = 32;
    localparam int CH      = 4;
    localparam int IW      = 2;
    localparam int ACK_LAT = 4;

    logic                 src_clk = 1'b0;
    logic                 src_rst;
    logic [CH-1:0][W-1:0] src_data;
    logic [CH-1:0]        src_force;
    logic [IW+W-1:0]      cdc_word;
    logic                 cdc_send;
    logic                 cdc_rcv;
    logic [CH-1:0]        pending;
    logic                 busy;
`ifdef PIRADIP_CDC_COALESCE_COUNT_EN
    logic [15:0]          coalesced_cnt;
`endif

    always #5 src_clk = ~src_clk;

    piradip_cdc_reg_bank_tx #(.WIDTH(W), .CHANNELS(CH)) dut (
        .src_clk   (src_clk),
        .src_rst   (src_rst),
        .src_data  (src_data),
        .src_force (src_force),
        .cdc_word  (cdc_word),
        .cdc_send  (cdc_send),
        .cdc_rcv   (cdc_rcv),
        .pending   (pending),
        .busy      (busy)
`ifdef PIRADIP_CDC_COALESCE_COUNT_EN
        ,
        .coalesced_cnt (coalesced_cnt)
`endif
    );

    typedef struct {
        int              ch;
        logic [W-1:0]    val;
        logic [IW+W-1:0] exp_word;
    } vec_t;

    vec_t            vecs[5];
    logic [IW+W-1:0] exp_seq[4];
    logic [IW+W-1:0] xfer_log[$];
    logic            rcv_override = 1'b0;
    int              n_checks = 0;
    int              n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [IW+W-1:0] log_at(input int k);
        return (k >= 0 && k < xfer_log.size()) ? xfer_log[k] : '1;
    endfunction

    task automatic wait_idle(input string name);
        int n = 0;
        repeat (2) @(negedge src_clk);
        while ((busy || cdc_send || cdc_rcv) && n < 400) begin
            @(negedge src_clk);
            n++;
        end
        check({name, "_idle"}, {61'b0, busy, cdc_send, cdc_rcv}, 64'h0);
    endtask

    // Handshake model: raise cdc_rcv ACK_LAT cycles after cdc_send, drop it ACK_LAT after send falls.
    initial begin : cdc_model
        int              cnt;
        logic            send_prev;
        logic [IW+W-1:0] word_at_send;
        cnt = 0;
        send_prev = 1'b0;
        word_at_send = '0;
        forever begin
            @(negedge src_clk);
            if (cdc_send && !send_prev) begin
                check("send_rise_rcv_low", 64'(cdc_rcv), 64'h0);
                word_at_send = cdc_word;
            end
            send_prev = cdc_send;
            if (rcv_override) begin
                cnt = 0;
            end else if (!cdc_rcv) begin
                if (cdc_send) begin
                    cnt++;
                    if (cnt == ACK_LAT) begin
                        check("word_stable", 64'(cdc_word), 64'(word_at_send));
                        xfer_log.push_back(cdc_word);
                        cdc_rcv = 1'b1;
                        cnt = 0;
                    end
                end else begin
                    cnt = 0;
                end
            end else begin
                if (!cdc_send) begin
                    cnt++;
                    if (cnt == ACK_LAT) begin
                        cdc_rcv = 1'b0;
                        cnt = 0;
                    end
                end else begin
                    cnt = 0;
                end
            end
        end
    end

    initial begin
        int n;
        vecs[0] = '{ch: 3, val: 32'hDEADBEEF, exp_word: 34'h3_DEADBEEF};
        vecs[1] = '{ch: 1, val: 32'h12345678, exp_word: 34'h1_12345678};
        vecs[2] = '{ch: 2, val: 32'hFFFFFFFF, exp_word: 34'h2_FFFFFFFF};
        vecs[3] = '{ch: 1, val: 32'h00000000, exp_word: 34'h1_00000000};
        vecs[4] = '{ch: 0, val: 32'h00000001, exp_word: 34'h0_00000001};

        src_rst   = 1'b1;
        src_force = '0;
        cdc_rcv   = 1'b0;
        src_data  = '0;
        src_data[1] = 32'h5;
        repeat (3) @(negedge src_clk);
        check("reset_send",    64'(cdc_send), 64'h0);
        check("reset_word",    64'(cdc_word), 64'h0);
        check("reset_pending", 64'(pending),  64'h0);
        check("reset_busy",    64'(busy),     64'h0);

        // Initial sync: only ch1 is nonzero.
        src_rst = 1'b0;
        wait_idle("t1");
        check("t1_count", 64'(xfer_log.size()), 64'd1);
        check("t1_word",  64'(log_at(0)), 64'h1_00000005);

        // Three back-to-back changes on ch2; the grant lands on the second one.
        xfer_log.delete();
        @(negedge src_clk) src_data[2] = 32'hA;
        @(negedge src_clk) src_data[2] = 32'hB;
        @(negedge src_clk) src_data[2] = 32'hC;
        wait_idle("t2");
        check("t2_count_le2", 64'(xfer_log.size() <= 2), 64'h1);
        check("t2_last_word", 64'(log_at(xfer_log.size() - 1)), 64'h2_0000000C);
`ifdef PIRADIP_CDC_COALESCE_COUNT_EN
        check("t2_coalesced_cnt", 64'(coalesced_cnt), 64'd1);
`endif

        for (int k = 0; k < 5; k++) begin
            xfer_log.delete();
            @(negedge src_clk) src_data[vecs[k].ch] = vecs[k].val;
            wait_idle($sformatf("vec%0d", k));
            check($sformatf("vec%0d_count", k), 64'(xfer_log.size()), 64'd1);
            check($sformatf("vec%0d_word", k), 64'(log_at(0)), 64'(vecs[k].exp_word));
        end

        // Force all channels with the pointer left at ch0.
        exp_seq[0] = 34'h1_00000000;
        exp_seq[1] = 34'h2_FFFFFFFF;
        exp_seq[2] = 34'h3_DEADBEEF;
        exp_seq[3] = 34'h0_00000001;
        xfer_log.delete();
        @(negedge src_clk) src_force = '1;
        @(negedge src_clk) src_force = '0;
        check("t3_pending_all", 64'(pending), 64'hF);
        wait_idle("t3");
        check("t3_count", 64'(xfer_log.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t3_word%0d", k), 64'(log_at(k)), 64'(exp_seq[k]));
        end

        // cdc_rcv held high blocks every grant.
        @(negedge src_clk);
        rcv_override = 1'b1;
        cdc_rcv = 1'b1;
        src_data[0] = 32'h2;
        src_data[1] = 32'h3;
        xfer_log.delete();
        for (int k = 0; k < 20; k++) begin
            @(negedge src_clk);
            check("t4_send_low", 64'(cdc_send), 64'h0);
            check("t4_pending",  64'(pending),  64'h3);
        end
        cdc_rcv = 1'b0;
        rcv_override = 1'b0;
        wait_idle("t4");
        check("t4_count", 64'(xfer_log.size()), 64'd2);
        check("t4_word0", 64'(log_at(0)), 64'h1_00000003);
        check("t4_word1", 64'(log_at(1)), 64'h0_00000002);

        // Reset while in SEND, with cdc_rcv still high afterwards.
        @(negedge src_clk);
        rcv_override = 1'b1;
        cdc_rcv = 1'b0;
        src_data[3] = 32'h55;
        xfer_log.delete();
        n = 0;
        while (!cdc_send && n < 20) begin
            @(negedge src_clk);
            n++;
        end
        check("t5_send_rise", 64'(cdc_send), 64'h1);
        @(negedge src_clk);
        src_rst = 1'b1;
        cdc_rcv = 1'b1;
        @(negedge src_clk);
        check("t5_send_dropped", 64'(cdc_send), 64'h0);
        check("t5_pending_clr",  64'(pending),  64'h0);
        check("t5_busy_clr",     64'(busy),     64'h0);
        check("t5_word_clr",     64'(cdc_word), 64'h0);
        src_rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge src_clk);
            check("t5_hold_send", 64'(cdc_send), 64'h0);
            check("t5_resync",    64'(pending),  64'hF);
        end
        rcv_override = 1'b0;
        wait_idle("t5");
        exp_seq[0] = 34'h1_00000003;
        exp_seq[1] = 34'h2_FFFFFFFF;
        exp_seq[2] = 34'h3_00000055;
        exp_seq[3] = 34'h0_00000002;
        check("t5_count", 64'(xfer_log.size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t5_word%0d", k), 64'(log_at(k)), 64'(exp_seq[k]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
